// File: rtl/frame_aligner.sv
// Receive-side frame aligner: hunts for the two-byte FAS, confirms lock over
// consecutive frames, then forwards frame-aligned bytes. Optional macro FRAME_ALIGNER_FAS_TOL_EN.
module frame_aligner #(
    parameter int          FRAME_LEN    = 4096,
    parameter logic [7:0]  FAS_B0       = 8'hF6,
    parameter logic [7:0]  FAS_B1       = 8'h28,
    parameter int          SYNC_CONFIRM = 2,
    parameter int          LOSS_THRESH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_valid,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    output logic       o_lof
);
    localparam int PW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t        state, state_nx;
    logic [7:0]    s0;
    logic [PW-1:0] pos, pos_nx, pos_inc;
    logic [2:0]    ccnt, ccnt_nx, ccnt_inc;
    logic [2:0]    mcnt, mcnt_nx, mcnt_inc;
    logic          match_exact, match_sync, chk_pt;
    logic          emit, emit_fas;

    assign match_exact = (s0 == FAS_B0) && (i_rx_data == FAS_B1);

`ifdef FRAME_ALIGNER_FAS_TOL_EN
    // In SYNC a single bit error in the FAS pair is forgiven.
    logic [15:0] fas_diff;
    assign fas_diff   = {s0, i_rx_data} ^ {FAS_B0, FAS_B1};
    assign match_sync = ($countones(fas_diff) <= 1);
`else
    assign match_sync = match_exact;
`endif

    assign chk_pt   = (pos == PW'(1));
    assign pos_inc  = (pos == PW'(FRAME_LEN - 1)) ? '0 : pos + PW'(1);
    assign ccnt_inc = ccnt + 3'd1;
    assign mcnt_inc = mcnt + 3'd1;

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        ccnt_nx  = ccnt;
        mcnt_nx  = mcnt;
        emit     = 1'b0;
        emit_fas = 1'b0;
        if (i_rx_data_valid) begin
            case (state)
                HUNT: begin
                    if (match_exact) begin
                        state_nx = PRESYNC;
                        pos_nx   = PW'(2);
                        ccnt_nx  = 3'd1;
                    end
                end
                PRESYNC: begin
                    pos_nx = pos_inc;
                    if (chk_pt) begin
                        if (match_exact) begin
                            ccnt_nx = ccnt_inc;
                            // Locking beat already carries FAS_B0 in s0, so emit it.
                            if (ccnt_inc == 3'(SYNC_CONFIRM)) begin
                                state_nx = SYNC;
                                mcnt_nx  = 3'd0;
                                emit     = 1'b1;
                                emit_fas = 1'b1;
                            end
                        end else begin
                            state_nx = HUNT;
                        end
                    end
                end
                SYNC: begin
                    pos_nx   = pos_inc;
                    emit     = 1'b1;
                    emit_fas = chk_pt;
                    if (chk_pt) begin
                        if (match_sync) begin
                            mcnt_nx = 3'd0;
                        end else begin
                            mcnt_nx = mcnt_inc;
                            if (mcnt_inc == 3'(LOSS_THRESH)) begin
                                state_nx = HUNT;
                                emit     = 1'b0;
                                emit_fas = 1'b0;
                            end
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= HUNT;
            s0                 <= 8'h00;
            pos                <= '0;
            ccnt               <= 3'd0;
            mcnt               <= 3'd0;
            o_frame_data       <= 8'h00;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_lof              <= 1'b1;
        end else begin
            state              <= state_nx;
            pos                <= pos_nx;
            ccnt               <= ccnt_nx;
            mcnt               <= mcnt_nx;
            if (i_rx_data_valid)
                s0 <= i_rx_data;
            if (emit)
                o_frame_data <= s0;
            o_frame_data_valid <= emit;
            o_frame_data_fas   <= emit_fas;
            o_lof              <= (state_nx != SYNC);
        end
    end
endmodule
